// File: rtl/fetch_queue_pkg.sv
// ============================================================================
// Module : fetch_queue_pkg
// Brief  : Shared widths and constants for the fetch/decode/issue front end.
//          PC_W   - word-addressed instruction ROM pc width
//          INST_W - instruction width
//          NOP_INST - canonical NOP (addi x0,x0,0) driven on empty slots
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fetch_queue_pkg;

  localparam int          PC_W     = 13;
  localparam int          INST_W   = 32;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

endpackage : fetch_queue_pkg

`default_nettype wire

// File: rtl/fq_ram.sv
// ============================================================================
// Module : fq_ram
// Brief  : DEPTH x WIDTH storage for the fetch queue. Two synchronous write
//          ports (callers guarantee distinct addresses when both are enabled)
//          and two asynchronous read ports. Contents are not reset.
// Ports  : CLK                  clock
//          we1/wa1/wd1          write port 1
//          we2/wa2/wd2          write port 2
//          ra1/rd1, ra2/rd2     asynchronous read ports
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fq_ram
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = PC_W + INST_W
) (
  input  logic                     CLK,
  input  logic                     we1,
  input  logic [$clog2(DEPTH)-1:0] wa1,
  input  logic [WIDTH-1:0]         wd1,
  input  logic                     we2,
  input  logic [$clog2(DEPTH)-1:0] wa2,
  input  logic [WIDTH-1:0]         wd2,
  input  logic [$clog2(DEPTH)-1:0] ra1,
  output logic [WIDTH-1:0]         rd1,
  input  logic [$clog2(DEPTH)-1:0] ra2,
  output logic [WIDTH-1:0]         rd2
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge CLK) begin
    if (we1) mem_q[wa1] <= wd1;
    if (we2) mem_q[wa2] <= wd2;
  end

  assign rd1 = mem_q[ra1];
  assign rd2 = mem_q[ra2];

endmodule : fq_ram

`default_nettype wire

// File: rtl/fetch_queue.sv
// ============================================================================
// Module : fetch_queue
// Brief  : Dual-in / dual-out instruction buffer between fetch and the
//          dual-issue pairing check. Fetch pushes 0/1/2 {pc,inst} pairs per
//          cycle, issue pops 0/1/2 per cycle; flush empties the queue.
// Ports  : CLK, NRST (async active-low)
//          flush                       mispredict flush, highest priority
//          in_valid[1:0], in_pc1/2, in_inst1/2   push side (slot1 older)
//          in_ready                    at least two free entries
//          pop_cnt[1:0]                entries consumed this cycle (3 == 2)
//          out_valid[1:0], out_pc1/2, out_inst1/2  head and head+1
//          count                       current occupancy
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     CLK,
  input  logic                     NRST,
  input  logic                     flush,
  input  logic [1:0]               in_valid,
  input  logic [PC_W-1:0]          in_pc1,
  input  logic [INST_W-1:0]        in_inst1,
  input  logic [PC_W-1:0]          in_pc2,
  input  logic [INST_W-1:0]        in_inst2,
  output logic                     in_ready,
  input  logic [1:0]               pop_cnt,
  output logic [1:0]               out_valid,
  output logic [PC_W-1:0]          out_pc1,
  output logic [INST_W-1:0]        out_inst1,
  output logic [PC_W-1:0]          out_pc2,
  output logic [INST_W-1:0]        out_inst2,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = PC_W + INST_W;

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;

  logic [1:0]       n_push;
  logic [1:0]       n_pop;
  logic [1:0]       pop_req;
  logic             we1, we2;
  logic [ENT_W-1:0] rd1, rd2;

  // Readiness depends on registered occupancy only, so fetch never sees a
  // combinational path from the issue side.
  assign in_ready = (count_q <= CNT_W'(DEPTH - 2));

  always_comb begin
    n_push  = 2'd0;
    n_pop   = 2'd0;
    pop_req = pop_cnt[1] ? 2'd2 : pop_cnt;
    we1     = 1'b0;
    we2     = 1'b0;

    // in_valid=10 is not a legal encoding and pushes nothing.
    if (in_ready) begin
      if (in_valid == 2'b11)      n_push = 2'd2;
      else if (in_valid == 2'b01) n_push = 2'd1;
    end

    // Pop is clipped against pre-push occupancy; count_q < 2 fits in 2 bits.
    n_pop = (count_q < CNT_W'(pop_req)) ? count_q[1:0] : pop_req;

    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      we1      = (n_push != 2'd0);
      we2      = (n_push == 2'd2);
      rd_ptr_d = rd_ptr_q + PTR_W'(n_pop);
      wr_ptr_d = wr_ptr_q + PTR_W'(n_push);
      count_d  = count_q + CNT_W'(n_push) - CNT_W'(n_pop);
    end
  end

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  fq_ram #(
    .DEPTH (DEPTH),
    .WIDTH (ENT_W)
  ) u_ram (
    .CLK (CLK),
    .we1 (we1),
    .wa1 (wr_ptr_q),
    .wd1 ({in_pc1, in_inst1}),
    .we2 (we2),
    .wa2 (wr_ptr_q + PTR_W'(1)),
    .wd2 ({in_pc2, in_inst2}),
    .ra1 (rd_ptr_q),
    .rd1 (rd1),
    .ra2 (rd_ptr_q + PTR_W'(1)),
    .rd2 (rd2)
  );

  assign out_valid = (count_q == '0)          ? 2'b00 :
                     (count_q == CNT_W'(1))   ? 2'b01 : 2'b11;

  // Empty slots present a clean NOP so downstream never sees stale storage.
  assign out_pc1   = out_valid[0] ? rd1[ENT_W-1:INST_W] : '0;
  assign out_inst1 = out_valid[0] ? rd1[INST_W-1:0]     : NOP_INST;
  assign out_pc2   = out_valid[1] ? rd2[ENT_W-1:INST_W] : '0;
  assign out_inst2 = out_valid[1] ? rd2[INST_W-1:0]     : NOP_INST;
  assign count     = count_q;

`ifndef SYNTHESIS
  a_in_valid_legal : assert property (@(posedge CLK) disable iff (!NRST)
    in_valid != 2'b10);
`endif

endmodule : fetch_queue

`default_nettype wire

// File: tb/tb_fetch_queue.sv
// ============================================================================
// Module : tb_fetch_queue
// Brief  : Directed self-checking bench for fetch_queue.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_queue;

  localparam int          DEPTH = 8;
  localparam int          PC_W  = 13;
  localparam int          IW    = 32;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic            CLK = 1'b0;
  logic            NRST = 1'b0;
  logic            flush = 1'b0;
  logic [1:0]      in_valid = 2'b00;
  logic [PC_W-1:0] in_pc1 = '0, in_pc2 = '0;
  logic [IW-1:0]   in_inst1 = '0, in_inst2 = '0;
  logic            in_ready;
  logic [1:0]      pop_cnt = 2'd0;
  logic [1:0]      out_valid;
  logic [PC_W-1:0] out_pc1, out_pc2;
  logic [IW-1:0]   out_inst1, out_inst2;
  logic [3:0]      count;

  int checks = 0;
  int errors = 0;

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .CLK       (CLK),
    .NRST      (NRST),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_pc1    (in_pc1),
    .in_inst1  (in_inst1),
    .in_pc2    (in_pc2),
    .in_inst2  (in_inst2),
    .in_ready  (in_ready),
    .pop_cnt   (pop_cnt),
    .out_valid (out_valid),
    .out_pc1   (out_pc1),
    .out_inst1 (out_inst1),
    .out_pc2   (out_pc2),
    .out_inst2 (out_inst2),
    .count     (count)
  );

  always #5 CLK = ~CLK;

  function automatic logic [IW-1:0] inst_of(input logic [PC_W-1:0] pc);
    return 32'hC0DE_0000 | {19'd0, pc};
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    in_valid = 2'b00;
    pop_cnt  = 2'd0;
    flush    = 1'b0;
  endtask

  task automatic push(input logic [1:0] v, input logic [PC_W-1:0] pc);
    in_valid = v;
    in_pc1   = pc;
    in_inst1 = inst_of(pc);
    in_pc2   = pc + 1'b1;
    in_inst2 = inst_of(pc + 1'b1);
  endtask

  task automatic do_reset();
    idle();
    NRST = 1'b0;
    tick();
    tick();
    NRST = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (count !== 4'd0)     begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
    checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL reset_ready: got %0b expected 1", in_ready); end
    checks++; if (out_valid !== 2'b00) begin errors++; $display("FAIL reset_valid: got %b expected 00", out_valid); end
    checks++; if (out_pc1 !== '0)     begin errors++; $display("FAIL reset_pc1: got %0h expected 0", out_pc1); end
    checks++; if (out_inst1 !== NOP || out_inst2 !== NOP)
      begin errors++; $display("FAIL reset_inst: got %0h/%0h expected %0h", out_inst1, out_inst2, NOP); end
  endtask

  task automatic test_basic_push();
    do_reset();
    push(2'b11, 13'h000);
    tick();
    idle();
    checks++; if (out_valid !== 2'b11) begin errors++; $display("FAIL basic_valid: got %b expected 11", out_valid); end
    checks++; if (out_pc1 !== 13'h000 || out_pc2 !== 13'h001)
      begin errors++; $display("FAIL basic_pc: got %0h/%0h expected 0/1", out_pc1, out_pc2); end
    checks++; if (out_inst1 !== inst_of(13'h000) || out_inst2 !== inst_of(13'h001))
      begin errors++; $display("FAIL basic_inst: got %0h/%0h expected %0h/%0h", out_inst1, out_inst2, inst_of(13'h000), inst_of(13'h001)); end
    checks++; if (count !== 4'd2) begin errors++; $display("FAIL basic_count: got %0d expected 2", count); end
  endtask

  task automatic test_full();
    logic [3:0] exp_cnt;
    logic       exp_rdy;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      push(2'b11, 13'(2 * i));
      tick();
      exp_cnt = (i < 4) ? 4'(2 * (i + 1)) : 4'd8;
      exp_rdy = (exp_cnt <= 4'd6);
      checks++; if (count !== exp_cnt || in_ready !== exp_rdy)
        begin errors++; $display("FAIL full_push%0d: got count=%0d ready=%0b expected count=%0d ready=%0b", i, count, in_ready, exp_cnt, exp_rdy); end
    end
    idle();
    checks++; if (out_pc1 !== 13'h000 || out_pc2 !== 13'h001)
      begin errors++; $display("FAIL full_head: got %0h/%0h expected 0/1", out_pc1, out_pc2); end
    // Pop from a full queue while pushing: the push is still dropped.
    push(2'b11, 13'h100);
    pop_cnt = 2'd2;
    tick();
    idle();
    checks++; if (count !== 4'd6 || out_pc1 !== 13'h002 || in_ready !== 1'b1)
      begin errors++; $display("FAIL full_pop: got count=%0d pc1=%0h ready=%0b expected 6/2/1", count, out_pc1, in_ready); end
    // Single pop (dependent pair) advances by one.
    pop_cnt = 2'd1;
    tick();
    idle();
    checks++; if (count !== 4'd5 || out_pc1 !== 13'h003 || out_pc2 !== 13'h004)
      begin errors++; $display("FAIL pop_one: got count=%0d pc=%0h/%0h expected 5/3/4", count, out_pc1, out_pc2); end
  endtask

  task automatic test_pop_clip();
    do_reset();
    push(2'b01, 13'h010);
    tick();
    checks++; if (count !== 4'd1 || out_valid !== 2'b01 || out_inst2 !== NOP)
      begin errors++; $display("FAIL clip_single: got count=%0d valid=%b inst2=%0h expected 1/01/13", count, out_valid, out_inst2); end
    push(2'b11, 13'h020);
    pop_cnt = 2'd2;
    checks++; if (out_pc1 !== 13'h010) begin errors++; $display("FAIL clip_head: got %0h expected 10", out_pc1); end
    tick();
    idle();
    checks++; if (count !== 4'd2 || out_pc1 !== 13'h020 || out_pc2 !== 13'h021)
      begin errors++; $display("FAIL clip_after: got count=%0d pc=%0h/%0h expected 2/20/21", count, out_pc1, out_pc2); end
    pop_cnt = 2'd3;
    tick();
    idle();
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL pop3_as2: got %0d expected 0", count); end
    pop_cnt = 2'd2;
    tick();
    idle();
    checks++; if (count !== 4'd0 || out_valid !== 2'b00)
      begin errors++; $display("FAIL no_underflow: got count=%0d valid=%b expected 0/00", count, out_valid); end
    // Illegal 10 pushes nothing (assertion is disabled only in reset, so avoid driving it).
  endtask

  task automatic test_wrap();
    logic [PC_W-1:0] exp_pc;
    exp_pc = '0;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      push(2'b11, 13'(2 * i));
      pop_cnt = 2'd2;
      if (i > 0) begin
        checks++; if (out_pc1 !== exp_pc || out_pc2 !== exp_pc + 1'b1 || out_inst2 !== inst_of(exp_pc + 1'b1))
          begin errors++; $display("FAIL wrap_%0d: got %0h/%0h expected %0h/%0h", i, out_pc1, out_pc2, exp_pc, exp_pc + 1'b1); end
        exp_pc = exp_pc + 2'd2;
      end
      tick();
    end
    idle();
    checks++; if (count !== 4'd2 || out_pc1 !== 13'd38 || out_pc2 !== 13'd39)
      begin errors++; $display("FAIL wrap_tail: got count=%0d pc=%0d/%0d expected 2/38/39", count, out_pc1, out_pc2); end
  endtask

  task automatic test_flush();
    do_reset();
    push(2'b11, 13'h040); tick();
    push(2'b11, 13'h042); tick();
    push(2'b01, 13'h044); tick();
    checks++; if (count !== 4'd5) begin errors++; $display("FAIL flush_pre: got %0d expected 5", count); end
    push(2'b11, 13'h046);
    pop_cnt = 2'd2;
    flush   = 1'b1;
    tick();
    idle();
    checks++; if (count !== 4'd0 || out_valid !== 2'b00 || out_inst1 !== NOP || out_pc1 !== '0 || in_ready !== 1'b1)
      begin errors++; $display("FAIL flush_state: got count=%0d valid=%b inst1=%0h pc1=%0h rdy=%0b expected 0/00/13/0/1", count, out_valid, out_inst1, out_pc1, in_ready); end
    push(2'b11, 13'h050);
    tick();
    idle();
    checks++; if (out_pc1 !== 13'h050 || out_pc2 !== 13'h051 || count !== 4'd2)
      begin errors++; $display("FAIL flush_refill: got pc=%0h/%0h count=%0d expected 50/51/2", out_pc1, out_pc2, count); end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      push(2'b11, 13'(8 * i));
      tick();
    end
    idle();
    checks++; if (count !== 4'd6) begin errors++; $display("FAIL areset_pre: got %0d expected 6", count); end
    #2;
    NRST = 1'b0;
    #1;
    checks++; if (count !== 4'd0 || in_ready !== 1'b1 || out_valid !== 2'b00 || out_pc1 !== '0 || out_inst1 !== NOP)
      begin errors++; $display("FAIL areset_now: got count=%0d rdy=%0b valid=%b pc1=%0h inst1=%0h expected 0/1/00/0/13", count, in_ready, out_valid, out_pc1, out_inst1); end
    #1;
    NRST = 1'b1;
    tick();
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL areset_after: got %0d expected 0", count); end
  endtask

  initial begin
    test_reset();
    test_basic_push();
    test_full();
    test_pop_clip();
    test_wrap();
    test_flush();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_fetch_queue

`default_nettype wire
